// File: rtl/cic_output_scaler_pkg.sv
// Shared definitions for the CIC output scaler: default widths and saturation limits.
package cic_output_scaler_pkg;

    localparam int unsigned DEF_IN_W    = 36;
    localparam int unsigned DEF_OUT_W   = 16;
    localparam int unsigned DEF_SHIFT_W = 6;

    // Signed limits of a two's-complement word, held wide enough for any supported width.
    typedef struct packed {
        logic signed [63:0] max;
        logic signed [63:0] min;
    } sat_lim_t;

    function automatic sat_lim_t sat_limits(input int unsigned width);
        sat_lim_t lim;
        lim.max = (64'sd1 <<< (width - 1)) - 64'sd1;
        lim.min = -(64'sd1 <<< (width - 1));
        return lim;
    endfunction

endpackage

// File: rtl/round_half_even_shifter.sv
// Combinational arithmetic right shift with convergent (round-half-even) rounding.
// The result is one bit wider than the input so the +1 rounding step can never wrap.
// The caller must keep s below InputLengthBits.
module round_half_even_shifter
    import cic_output_scaler_pkg::*;
#(
    parameter int unsigned InputLengthBits = DEF_IN_W,
    parameter int unsigned ShiftBits       = DEF_SHIFT_W
) (
    input  logic signed [InputLengthBits-1:0] in,
    input  logic        [ShiftBits-1:0]       s,
    output logic signed [InputLengthBits:0]   q
);

    localparam int unsigned W = InputLengthBits + 1;

    logic signed [W-1:0] ext;
    logic signed [W-1:0] trunc;
    logic        [W-1:0] rem;
    logic        [W-1:0] half;

    // Floor shift, then bump by one when the discarded fraction is above half, or exactly half with an odd quotient.
    always_comb begin
        ext   = {in[InputLengthBits-1], in};
        trunc = ext >>> s;
        rem   = $unsigned(ext) & ~({W{1'b1}} << s);
        half  = ({{(W-1){1'b0}}, 1'b1} << s) >> 1;
        q     = trunc;
        if (s != '0) begin
            if (rem > half)
                q = trunc + W'(1);
            else if (rem == half)
                q = trunc + {{(W-1){1'b0}}, trunc[0]};
        end
    end

endmodule

// File: rtl/cic_output_scaler.sv
// CIC output scaler: runtime right shift with round-half-even, then saturation to a narrow word.
// Two-stage elastic pipeline with ready/valid on both sides.
// Build option CIC_OUTPUT_SCALER_STICKY_EN adds a sticky saturation flag (sat_clear / sat_sticky).
module cic_output_scaler
    import cic_output_scaler_pkg::*;
#(
    parameter int unsigned InputLengthBits  = DEF_IN_W,
    parameter int unsigned OutputLengthBits = DEF_OUT_W,
    parameter int unsigned ShiftBits        = DEF_SHIFT_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic signed [InputLengthBits-1:0]  in,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic        [ShiftBits-1:0]        shift,
    output logic signed [OutputLengthBits-1:0] out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_sat
`ifdef CIC_OUTPUT_SCALER_STICKY_EN
    ,
    input  logic                               sat_clear,
    output logic                               sat_sticky
`endif
);

    localparam sat_lim_t             LIM  = sat_limits(OutputLengthBits);
    localparam logic [ShiftBits-1:0] SMAX = ShiftBits'(InputLengthBits - 1);

    logic        [ShiftBits-1:0]        s_clamped;
    logic signed [InputLengthBits:0]    q_rnd;
    logic signed [InputLengthBits:0]    s1_q;
    logic                               s1_valid;
    logic                               s2_load;
    logic signed [63:0]                 q_wide;
    logic                               sat_hi;
    logic                               sat_lo;
    logic signed [OutputLengthBits-1:0] sat_val;

    // Shifting by the full width or more would discard everything, so cap at the widest useful shift.
    assign s_clamped = (shift > SMAX) ? SMAX : shift;

    round_half_even_shifter #(
        .InputLengthBits(InputLengthBits),
        .ShiftBits      (ShiftBits)
    ) u_rnd (
        .in(in),
        .s (s_clamped),
        .q (q_rnd)
    );

    // Output stage takes a new word when empty or when its word leaves this cycle.
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    // Clamp the rounded value from S1 to the output range.
    always_comb begin
        q_wide  = 64'(s1_q);
        sat_hi  = q_wide > LIM.max;
        sat_lo  = q_wide < LIM.min;
        sat_val = s1_q[OutputLengthBits-1:0];
        if (sat_hi)
            sat_val = OutputLengthBits'(LIM.max);
        else if (sat_lo)
            sat_val = OutputLengthBits'(LIM.min);
    end

    // S1: capture the rounded shift of each accepted input word.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid)
                s1_q <= q_rnd;
        end
    end

    // S2: capture the saturated result; holds while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_sat   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out     <= sat_val;
                out_sat <= sat_hi || sat_lo;
            end
        end
    end

`ifdef CIC_OUTPUT_SCALER_STICKY_EN
    // Sticky flag: a saturating output transfer sets it and takes priority over a clear.
    always_ff @(posedge clk) begin
        if (rst)
            sat_sticky <= 1'b0;
        else if (out_valid && out_ready && out_sat)
            sat_sticky <= 1'b1;
        else if (sat_clear)
            sat_sticky <= 1'b0;
    end
`endif

endmodule
